// File: rtl/instruction_fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding, the fetch stride and the default reset fetch address.
package instruction_fetch_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetchState_e;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_controller_if.sv
// Bus between the fetch controller, the combinational instruction memory
// and the decode stage. The controller uses the master modport and the
// surrounding pipeline (or a testbench) uses the slave modport.
interface instruction_fetch_controller_if #(
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] imemAddress;
  logic [31:0]           imemInstruction;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirectTarget;
  logic                  halt;
  logic                  outValid;
  logic                  outReady;
  logic [31:0]           outInstruction;
  logic [ADDR_WIDTH-1:0] outPc;
  logic [ADDR_WIDTH-1:0] outPcPlus4;
  logic                  halted;

  modport master (
    output imemAddress,
    input  imemInstruction,
    input  redirect,
    input  redirectTarget,
    input  halt,
    output outValid,
    input  outReady,
    output outInstruction,
    output outPc,
    output outPcPlus4,
    output halted
  );

  modport slave (
    input  imemAddress,
    output imemInstruction,
    output redirect,
    output redirectTarget,
    output halt,
    input  outValid,
    output outReady,
    input  outInstruction,
    input  outPc,
    input  outPcPlus4,
    input  halted
  );

endinterface

// File: rtl/instruction_fetch_controller_fetch_queue.sv
// Small prefetch FIFO holding {PC, instruction} pairs. Flush empties it in
// one cycle and wins over push/pop. DEPTH must be a power of two so the
// pointers wrap naturally.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [ADDR_WIDTH-1:0]      pushPc_i,
  input  logic [31:0]                pushInstr_i,
  output logic [ADDR_WIDTH-1:0]      headPc_o,
  output logic [31:0]                headInstr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] pcMem_q    [DEPTH];
  logic [31:0]           instrMem_q [DEPTH];
  logic [PW-1:0]         wrPtr_q;
  logic [PW-1:0]         rdPtr_q;
  logic [CW-1:0]         count_q;

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: the count gates whether the head is used.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      pcMem_q[wrPtr_q]    <= pushPc_i;
      instrMem_q[wrPtr_q] <= pushInstr_i;
    end
  end

  assign headPc_o    = pcMem_q[rdPtr_q];
  assign headInstr_o = instrMem_q[rdPtr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: owns the fetch PC, addresses the combinational
// instruction memory, buffers fetched words in a prefetch queue and offers
// the head entry to decode over valid/ready. Redirect flushes and reloads
// the PC from any state; Halt stops fetching and lets the queue drain.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    DEPTH      = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  instruction_fetch_controller_if.master fetchBus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetchState_e           state_q;
  logic                  halted_q;
  logic [ADDR_WIDTH-1:0] fetchPc_q;
  logic [ADDR_WIDTH-1:0] fetchPc_d;
  logic [ADDR_WIDTH-1:0] redirectPc;
  logic [ADDR_WIDTH-1:0] headPc;
  logic [31:0]           headInstr;
  logic [CW-1:0]         count;
  logic                  outValid;
  logic                  pop;
  logic                  push;

  assign outValid   = (count != '0);
  assign pop        = outValid && fetchBus.outReady;
  assign redirectPc = {fetchBus.redirectTarget[ADDR_WIDTH-1:2], 2'b00};

  // A full queue can still accept a new word when the head leaves this cycle.
  assign push = (state_q == ST_RUN) && !fetchBus.redirect && !fetchBus.halt &&
                ((count < CW'(DEPTH)) || pop);

  fetch_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fetchQueue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (fetchBus.redirect),
    .pushPc_i    (fetchPc_q),
    .pushInstr_i (fetchBus.imemInstruction),
    .headPc_o    (headPc),
    .headInstr_o (headInstr),
    .count_o     (count)
  );

  // Next fetch address: redirect reloads, a push advances, otherwise hold.
  always_comb begin
    fetchPc_d = fetchPc_q;
    if (fetchBus.redirect) begin
      fetchPc_d = redirectPc;
    end else if (push) begin
      fetchPc_d = fetchPc_q + ADDR_WIDTH'(PC_INC);
    end
  end

  // Run/drain/halted sequencing with the fetch PC and registered Halted flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      halted_q  <= 1'b0;
      fetchPc_q <= RESET_PC;
    end else begin
      fetchPc_q <= fetchPc_d;
      if (fetchBus.redirect) begin
        state_q  <= ST_RUN;
        halted_q <= 1'b0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (fetchBus.halt) begin
              state_q <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (count == '0) begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end
          end
          ST_HALTED: begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
          default: begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fetchBus.imemAddress    = fetchPc_q;
  assign fetchBus.outValid       = outValid;
  assign fetchBus.outInstruction = outValid ? headInstr : 32'h0;
  assign fetchBus.outPc          = outValid ? headPc : '0;
  assign fetchBus.outPcPlus4     = outValid ? (headPc + ADDR_WIDTH'(PC_INC)) : '0;
  assign fetchBus.halted         = halted_q;

endmodule
